regfile_wb_arbiter: RTL and testbench

- Writer side of the 32x32 register file write port.
- Merges writebacks from two producers and drives the single write port (we/waddr/wdata):
  - the in-order pipeline writeback (source A);
  - the long-latency mult/div unit (source B).
- Buffers B results in a small FIFO.
- Optionally tracks destinations pending on B (scoreboard) so decode can stall readers.

---
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) over buffered mult/div results (B).
// Define WB_SCOREBOARD_EN to track B-pending destinations and drive o_stall/o_busy_vec.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_a_valid,
    input  logic [AW-1:0] i_a_waddr,
    input  logic [DW-1:0] i_a_wdata,
    input  logic          i_b_valid,
    output logic          o_b_ready,
    input  logic [AW-1:0] i_b_waddr,
    input  logic [DW-1:0] i_b_wdata,
    input  logic          i_issue_valid,
    input  logic [AW-1:0] i_issue_waddr,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic          o_stall,
    output logic [31:0]   o_busy_vec,
    output logic          o_we,
    output logic [AW-1:0] o_waddr,
    output logic [DW-1:0] o_wdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } wb_t;

    wb_t           fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    wb_t           head;

    // Ready comes only from the registered count, so a same-cycle pop never raises it.
    assign o_b_ready = (count != CW'(DEPTH));
    assign push      = i_b_valid && o_b_ready;
    assign pop       = !i_a_valid && (count != '0);
    assign head      = fifo_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{waddr: i_b_waddr, wdata: i_b_wdata};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else if (i_a_valid) begin
            o_we    <= (i_a_waddr != '0);
            o_waddr <= i_a_waddr;
            o_wdata <= i_a_wdata;
        end else if (pop) begin
            o_we    <= (head.waddr != '0);
            o_waddr <= head.waddr;
            o_wdata <= head.wdata;
        end else begin
            o_we    <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Clear first so a same-cycle reissue to the same register keeps it pending.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.waddr] = 1'b0;
        end
        if (i_issue_valid && (i_issue_waddr != '0)) begin
            busy_d[i_issue_waddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy_vec = busy_q;
    assign o_stall    = busy_q[i_raddr1] | busy_q[i_raddr2] |
                        (i_issue_valid & busy_q[i_issue_waddr]);
`else
    logic unused_sb;

    assign unused_sb  = ^{i_issue_valid, i_issue_waddr, i_raddr1, i_raddr2};
    assign o_busy_vec = '0;
    assign o_stall    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; scoreboard scenarios build only with WB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_a_valid;
    logic [4:0]  i_a_waddr;
    logic [31:0] i_a_wdata;
    logic        i_b_valid;
    logic        o_b_ready;
    logic [4:0]  i_b_waddr;
    logic [31:0] i_b_wdata;
    logic        i_issue_valid;
    logic [4:0]  i_issue_waddr;
    logic [4:0]  i_raddr1;
    logic [4:0]  i_raddr2;
    logic        o_stall;
    logic [31:0] o_busy_vec;
    logic        o_we;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_a_valid(i_a_valid), .i_a_waddr(i_a_waddr), .i_a_wdata(i_a_wdata),
        .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
        .i_b_waddr(i_b_waddr), .i_b_wdata(i_b_wdata),
        .i_issue_valid(i_issue_valid), .i_issue_waddr(i_issue_waddr),
        .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
        .o_stall(o_stall), .o_busy_vec(o_busy_vec),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] a, input logic [31:0] d);
        i_a_valid = v;
        i_a_waddr = a;
        i_a_wdata = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] a, input logic [31:0] d);
        i_b_valid = v;
        i_b_waddr = a;
        i_b_wdata = d;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b0, 5'd0, 32'h0);
        i_issue_valid = 1'b0;
        i_issue_waddr = 5'd0;
        i_raddr1 = 5'd0;
        i_raddr2 = 5'd0;
        step();
        step();
        total++;
        if ({o_we, o_waddr, o_wdata} !== 38'h0) begin
            bad++;
            $display("FAIL reset_out: got we=%b a=%0d d=%h want 0/0/0", o_we, o_waddr, o_wdata);
        end
        total++;
        if (o_b_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", o_b_ready);
        end
        total++;
        if (o_busy_vec !== 32'h0 || o_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_sb: got busy=%h stall=%b want 0/0", o_busy_vec, o_stall);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_a_write();
        set_a(1'b1, 5'd5, 32'h1234);
        step();
        total++;
        if (o_we !== 1'b1 || o_waddr !== 5'd5 || o_wdata !== 32'h1234) begin
            bad++;
            $display("FAIL a_write: got we=%b a=%0d d=%h want 1/5/1234", o_we, o_waddr, o_wdata);
        end
        set_a(1'b0, 5'd0, 32'h0);
        step();
        total++;
        if (o_we !== 1'b0 || o_waddr !== 5'd5 || o_wdata !== 32'h1234) begin
            bad++;
            $display("FAIL a_idle_hold: got we=%b a=%0d d=%h want 0/5/1234", o_we, o_waddr, o_wdata);
        end
    endtask

    task automatic test_priority();
        logic [4:0]  exp_a [6];
        logic [31:0] exp_d [6];
        logic        exp_we [6];
        logic        exp_rdy [6];
        exp_a   = '{5'd10, 5'd11, 5'd12, 5'd3, 5'd4, 5'd4};
        exp_d   = '{32'h100, 32'h101, 32'h102, 32'hA, 32'hB, 32'hB};
        exp_we  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin set_a(1'b1, 5'd10, 32'h100); set_b(1'b1, 5'd3, 32'hA); end
                1: begin set_a(1'b1, 5'd11, 32'h101); set_b(1'b1, 5'd4, 32'hB); end
                2: begin set_a(1'b1, 5'd12, 32'h102); set_b(1'b1, 5'd5, 32'hC); end
                3: begin set_a(1'b0, 5'd0, 32'h0); end
                4: begin set_b(1'b0, 5'd0, 32'h0); end
                default: ;
            endcase
            step();
            total++;
            if (o_we !== exp_we[i] || o_waddr !== exp_a[i] || o_wdata !== exp_d[i]) begin
                bad++;
                $display("FAIL prio_out[%0d]: got we=%b a=%0d d=%h want %b/%0d/%h",
                         i, o_we, o_waddr, o_wdata, exp_we[i], exp_a[i], exp_d[i]);
            end
            total++;
            if (o_b_ready !== exp_rdy[i]) begin
                bad++;
                $display("FAIL prio_ready[%0d]: got %b want %b", i, o_b_ready, exp_rdy[i]);
            end
        end
    endtask

    task automatic test_reg0();
        set_a(1'b1, 5'd0, 32'h77);
        set_b(1'b1, 5'd0, 32'h88);
        step();
        total++;
        if (o_we !== 1'b0) begin
            bad++;
            $display("FAIL reg0_a: got we=%b want 0", o_we);
        end
        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b0, 5'd0, 32'h0);
        step();
        total++;
        if (o_we !== 1'b0 || o_b_ready !== 1'b1) begin
            bad++;
            $display("FAIL reg0_b: got we=%b rdy=%b want 0/1", o_we, o_b_ready);
        end
        set_b(1'b1, 5'd6, 32'h66);
        step();
        set_b(1'b0, 5'd0, 32'h0);
        total++;
        if (o_we !== 1'b0) begin
            bad++;
            $display("FAIL reg0_empty: got we=%b want 0", o_we);
        end
        step();
        total++;
        if (o_we !== 1'b1 || o_waddr !== 5'd6 || o_wdata !== 32'h66) begin
            bad++;
            $display("FAIL reg0_drained: got we=%b a=%0d d=%h want 1/6/66", o_we, o_waddr, o_wdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_a [4];
        logic [31:0] exp_d [4];
        logic        exp_we [4];
        exp_a  = '{5'd6, 5'd1, 5'd2, 5'd13};
        exp_d  = '{32'h66, 32'h11, 32'h22, 32'h33};
        exp_we = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_b(1'b1, 5'd1, 32'h11);
                1: set_b(1'b1, 5'd2, 32'h22);
                2: set_b(1'b1, 5'd13, 32'h33);
                default: set_b(1'b0, 5'd0, 32'h0);
            endcase
            step();
            total++;
            if (o_we !== exp_we[i] || o_waddr !== exp_a[i] || o_wdata !== exp_d[i]) begin
                bad++;
                $display("FAIL b2b[%0d]: got we=%b a=%0d d=%h want %b/%0d/%h",
                         i, o_we, o_waddr, o_wdata, exp_we[i], exp_a[i], exp_d[i]);
            end
        end
        step();
        total++;
        if (o_we !== 1'b0 || o_b_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_empty: got we=%b rdy=%b want 0/1", o_we, o_b_ready);
        end
    endtask

`ifdef WB_SCOREBOARD_EN
    task automatic test_scoreboard();
        i_issue_valid = 1'b1;
        i_issue_waddr = 5'd7;
        #1;
        total++;
        if (o_stall !== 1'b0) begin
            bad++;
            $display("FAIL sb_issue_free: got stall=%b want 0", o_stall);
        end
        step();
        i_issue_valid = 1'b0;
        i_raddr1 = 5'd7;
        #1;
        total++;
        if (o_stall !== 1'b1 || o_busy_vec !== 32'h80) begin
            bad++;
            $display("FAIL sb_set7: got stall=%b busy=%h want 1/00000080", o_stall, o_busy_vec);
        end
        set_b(1'b1, 5'd7, 32'h55);
        step();
        set_b(1'b0, 5'd0, 32'h0);
        total++;
        if (o_busy_vec !== 32'h80) begin
            bad++;
            $display("FAIL sb_push_keep: got busy=%h want 00000080", o_busy_vec);
        end
        step();
        total++;
        if (o_busy_vec !== 32'h0 || o_stall !== 1'b0 || o_waddr !== 5'd7 || o_wdata !== 32'h55) begin
            bad++;
            $display("FAIL sb_clear7: got busy=%h stall=%b a=%0d d=%h want 0/0/7/55",
                     o_busy_vec, o_stall, o_waddr, o_wdata);
        end
        i_raddr1 = 5'd0;
        i_issue_valid = 1'b1;
        i_issue_waddr = 5'd9;
        set_b(1'b1, 5'd9, 32'h99);
        step();
        set_b(1'b0, 5'd0, 32'h0);
        #1;
        total++;
        if (o_stall !== 1'b1) begin
            bad++;
            $display("FAIL sb_waw_stall: got stall=%b want 1", o_stall);
        end
        step();
        i_issue_valid = 1'b0;
        total++;
        if (o_busy_vec !== 32'h200 || o_waddr !== 5'd9) begin
            bad++;
            $display("FAIL sb_set_wins: got busy=%h a=%0d want 00000200/9", o_busy_vec, o_waddr);
        end
        i_raddr2 = 5'd0;
        #1;
        total++;
        if (o_stall !== 1'b0) begin
            bad++;
            $display("FAIL sb_r0: got stall=%b want 0", o_stall);
        end
    endtask
`endif

    task automatic test_reset_mid();
        set_a(1'b1, 5'd30, 32'h300);
        set_b(1'b1, 5'd20, 32'h1);
        i_issue_valid = 1'b1;
        i_issue_waddr = 5'd20;
        step();
        set_b(1'b1, 5'd21, 32'h2);
        i_issue_valid = 1'b0;
        step();
        set_b(1'b0, 5'd0, 32'h0);
        total++;
        if (o_b_ready !== 1'b0 || o_we !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: got rdy=%b we=%b want 0/1", o_b_ready, o_we);
        end
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (o_we !== 1'b0 || o_b_ready !== 1'b1 || o_busy_vec !== 32'h0) begin
            bad++;
            $display("FAIL rst_async: got we=%b rdy=%b busy=%h want 0/1/0", o_we, o_b_ready, o_busy_vec);
        end
        set_a(1'b0, 5'd0, 32'h0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (o_we !== 1'b0 || o_b_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_after[%0d]: got we=%b rdy=%b want 0/1", i, o_we, o_b_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_priority();
        test_reg0();
        test_back_to_back();
`ifdef WB_SCOREBOARD_EN
        test_scoreboard();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
